d_fifo_drain: RTL and testbench

- Downstream consumer of the two destination FIFOs (D0, D1) at the tail of the main→VC→D FIFO architecture.
- Generates pop_d0/pop_d1 from the empty flags and captures the popped words into a small tagged output buffer.
- Merges the words onto a single valid/ready stream carrying a destination tag.
- Keeps per-destination drained-word counters and an idle flag for the bench and checker.

---
 rtl/d_fifo_drain_if.sv | 31 +++
 rtl/d_fifo_drain.sv | 102 ++++++++++
 tb/tb_d_fifo_drain.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/d_fifo_drain_if.sv
// Bundle between the D0/D1 destination FIFOs, the drain block and its tagged output sink.
// The slave modport is the drain block's view; the master modport is the FIFO/sink side.
interface d_fifo_drain_if #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned CNT_W  = 8
);
    logic              drain_en;
    logic              fifo_empty_d0;
    logic              fifo_empty_d1;
    logic [DATA_W-1:0] data_in_d0;
    logic [DATA_W-1:0] data_in_d1;
    logic              ready_in;
    logic              pop_d0;
    logic              pop_d1;
    logic [DATA_W-1:0] data_out;
    logic              dest_out;
    logic              valid_out;
    logic [CNT_W-1:0]  count_d0;
    logic [CNT_W-1:0]  count_d1;
    logic              idle_out;

    modport slave (
        input  drain_en, fifo_empty_d0, fifo_empty_d1, data_in_d0, data_in_d1, ready_in,
        output pop_d0, pop_d1, data_out, dest_out, valid_out, count_d0, count_d1, idle_out
    );

    modport master (
        output drain_en, fifo_empty_d0, fifo_empty_d1, data_in_d0, data_in_d1, ready_in,
        input  pop_d0, pop_d1, data_out, dest_out, valid_out, count_d0, count_d1, idle_out
    );
endinterface

// File: rtl/d_fifo_drain.sv
// Drains the D0/D1 destination FIFOs round-robin into a small tagged buffer and
// presents the words on one valid/ready stream with per-destination drained counters.
module d_fifo_drain #(
    parameter int unsigned DATA_W    = 6,
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    d_fifo_drain_if.slave    bus
);
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [DATA_W-1:0]    r_buf_data [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] r_buf_tag;
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [OCC_W-1:0]     r_occ;
    logic                 r_inflight;
    logic                 r_inflight_tag;
    logic                 r_rr;
    logic [CNT_W-1:0]     r_cnt_d0;
    logic [CNT_W-1:0]     r_cnt_d1;

    logic [OCC_W:0]       w_pending;
    logic                 w_room;
    logic                 w_elig0;
    logic                 w_elig1;
    logic                 w_pop0;
    logic                 w_pop1;
    logic                 w_valid;
    logic                 w_xfer;
    logic                 w_head_tag;
    logic [DATA_W-1:0]    w_cap_data;

    // Room is judged against occupancy plus the word already in flight; a transfer
    // happening this same cycle is deliberately not credited.
    assign w_pending  = {1'b0, r_occ} + {{OCC_W{1'b0}}, r_inflight};
    assign w_room     = w_pending < (OCC_W+1)'(BUF_DEPTH);
    assign w_elig0    = bus.drain_en && !bus.fifo_empty_d0 && w_room;
    assign w_elig1    = bus.drain_en && !bus.fifo_empty_d1 && w_room;
    assign w_pop0     = !reset && w_elig0 && (!w_elig1 || !r_rr);
    assign w_pop1     = !reset && w_elig1 && (!w_elig0 || r_rr);

    assign w_valid    = r_occ != '0;
    assign w_xfer     = w_valid && bus.ready_in;
    assign w_head_tag = r_buf_tag[r_rptr];
    assign w_cap_data = r_inflight_tag ? bus.data_in_d1 : bus.data_in_d0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                r_buf_data[i] <= '0;
            end
            r_buf_tag      <= '0;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_occ          <= '0;
            r_inflight     <= 1'b0;
            r_inflight_tag <= 1'b0;
            r_rr           <= 1'b0;
            r_cnt_d0       <= '0;
            r_cnt_d1       <= '0;
        end else begin
            if (r_inflight) begin
                r_buf_data[r_wptr] <= w_cap_data;
                r_buf_tag[r_wptr]  <= r_inflight_tag;
                r_wptr             <= r_wptr + PTR_W'(1);
            end
            if (w_xfer) begin
                r_rptr <= r_rptr + PTR_W'(1);
                if (w_head_tag) begin
                    r_cnt_d1 <= r_cnt_d1 + CNT_W'(1);
                end else begin
                    r_cnt_d0 <= r_cnt_d0 + CNT_W'(1);
                end
            end
            case ({r_inflight, w_xfer})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
            r_inflight     <= w_pop0 || w_pop1;
            r_inflight_tag <= w_pop1;
            if (w_pop0) begin
                r_rr <= 1'b1;
            end else if (w_pop1) begin
                r_rr <= 1'b0;
            end
        end
    end

    assign bus.pop_d0    = w_pop0;
    assign bus.pop_d1    = w_pop1;
    assign bus.valid_out = w_valid;
    assign bus.data_out  = w_valid ? r_buf_data[r_rptr] : '0;
    assign bus.dest_out  = w_valid ? w_head_tag : 1'b0;
    assign bus.count_d0  = r_cnt_d0;
    assign bus.count_d1  = r_cnt_d1;
    assign bus.idle_out  = reset || (!w_valid && !r_inflight && bus.fifo_empty_d0 && bus.fifo_empty_d1);
endmodule

// File: tb/tb_d_fifo_drain.sv
// Directed bench for d_fifo_drain: FIFO models feed D0/D1, a scoreboard queue holds the
// hand-ordered expected {tag,data} stream and a monitor compares every output transfer.
module tb_d_fifo_drain;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    d_fifo_drain_if #(.DATA_W(6), .CNT_W(8)) bus ();

    d_fifo_drain #(.DATA_W(6), .BUF_DEPTH(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [6:0] sbq [$];

    logic [5:0] mem0 [512];
    logic [5:0] mem1 [512];
    int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
    int out_cnt;

    assign bus.fifo_empty_d0 = (rd0 == wr0);
    assign bus.fifo_empty_d1 = (rd1 == wr1);

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO models: pop sampled at posedge, data valid the following cycle
    always @(posedge clk) begin
        if (!reset && bus.pop_d0) begin
            bus.data_in_d0 <= mem0[rd0];
            rd0 <= rd0 + 1;
        end
        if (!reset && bus.pop_d1) begin
            bus.data_in_d1 <= mem1[rd1];
            rd1 <= rd1 + 1;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) out_cnt <= 0;
        else out_cnt <= out_cnt + ((bus.pop_d0 || bus.pop_d1) ? 1 : 0)
                                - ((bus.valid_out && bus.ready_in) ? 1 : 0);
    end

    // Monitor: samples 1 time unit before each posedge
    initial begin
        logic [6:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (!reset) begin
                check("outstanding_le_depth", int'(out_cnt <= 4), 1);
                if (bus.valid_out && bus.ready_in) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_word", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        check("data_out", bus.data_out, e[5:0]);
                        check("dest_out", bus.dest_out, e[6]);
                    end
                end
            end
        end
    end

    task automatic push0(input logic [5:0] d);
        mem0[wr0] = d;
        wr0++;
    endtask

    task automatic push1(input logic [5:0] d);
        mem1[wr1] = d;
        wr1++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (c < budget && !(sbq.size() == 0 && bus.idle_out)) begin
            @(negedge clk);
            c++;
        end
        #1;
        check("drain_done", int'(sbq.size() == 0 && bus.idle_out), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int np;
        reset = 1'b1;
        bus.drain_en = 1'b0;
        bus.ready_in = 1'b0;
        bus.data_in_d0 = '0;
        bus.data_in_d1 = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", bus.valid_out, 0);
        check("rst_data", bus.data_out, 0);
        check("rst_dest", bus.dest_out, 0);
        check("rst_pop_d0", bus.pop_d0, 0);
        check("rst_pop_d1", bus.pop_d1, 0);
        check("rst_cnt_d0", bus.count_d0, 0);
        check("rst_cnt_d1", bus.count_d1, 0);
        check("rst_idle", bus.idle_out, 1);
        @(negedge clk);
        reset = 1'b0;

        // D0 only: three back-to-back pops, valid two edges after the first
        do_reset();
        bus.drain_en = 1'b1;
        bus.ready_in = 1'b1;
        push0(6'h2D); push0(6'h2E); push0(6'h2F);
        sbq.push_back({1'b0, 6'h2D}); sbq.push_back({1'b0, 6'h2E}); sbq.push_back({1'b0, 6'h2F});
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t1_pop_d0", bus.pop_d0, (i < 3) ? 1 : 0);
            if (i < 3) check("t1_valid", bus.valid_out, (i >= 2) ? 1 : 0);
            @(negedge clk);
        end
        wait_drain(20);
        check("t1_cnt_d0", bus.count_d0, 3);
        check("t1_cnt_d1", bus.count_d1, 0);

        // Both FIFOs: round-robin from D0
        do_reset();
        bus.drain_en = 1'b1;
        bus.ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push0(6'h01 + 6'(i));
            push1(6'h11 + 6'(i));
            sbq.push_back({1'b0, 6'h01 + 6'(i)});
            sbq.push_back({1'b1, 6'h11 + 6'(i)});
        end
        for (int i = 0; i < 8; i++) begin
            #1;
            check("t2_pop_d0", bus.pop_d0, (i % 2 == 0) ? 1 : 0);
            check("t2_pop_d1", bus.pop_d1, (i % 2 == 1) ? 1 : 0);
            @(negedge clk);
        end
        wait_drain(30);
        check("t2_cnt_d0", bus.count_d0, 4);
        check("t2_cnt_d1", bus.count_d1, 4);

        // Backpressure: buffer fills to 4 and pops stop
        do_reset();
        bus.drain_en = 1'b1;
        bus.ready_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push0(6'h20 + 6'(i));
            push1(6'h30 + 6'(i));
            sbq.push_back({1'b0, 6'h20 + 6'(i)});
            sbq.push_back({1'b1, 6'h30 + 6'(i)});
        end
        np = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            np += int'(bus.pop_d0) + int'(bus.pop_d1);
            @(negedge clk);
        end
        #1;
        check("t3_pops_total", np, 4);
        check("t3_valid", bus.valid_out, 1);
        check("t3_data_hold", bus.data_out, 6'h20);
        check("t3_dest_hold", bus.dest_out, 0);
        @(negedge clk);
        #1;
        check("t3_data_stable", bus.data_out, 6'h20);
        check("t3_no_pop", int'(bus.pop_d0) + int'(bus.pop_d1), 0);
        @(negedge clk);
        bus.ready_in = 1'b1;
        np = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_xfer_valid", bus.valid_out, 1);
            np += int'(bus.pop_d0) + int'(bus.pop_d1);
            @(negedge clk);
        end
        check("t3_pops_resume", np, 3);
        wait_drain(40);
        check("t3_cnt_d0", bus.count_d0, 6);
        check("t3_cnt_d1", bus.count_d1, 6);

        // Reset mid-cycle with occ=2 and 0x0C in flight
        do_reset();
        bus.drain_en = 1'b1;
        bus.ready_in = 1'b0;
        push0(6'h0A); push0(6'h0B); push0(6'h0C); push0(6'h0D); push0(6'h0E);
        sbq.push_back({1'b0, 6'h0D}); sbq.push_back({1'b0, 6'h0E});
        repeat (3) @(negedge clk);
        #1;
        check("t4_pre_valid", bus.valid_out, 1);
        check("t4_pre_data", bus.data_out, 6'h0A);
        #1;
        reset = 1'b1;
        #1;
        check("t4_rst_pop_d0", bus.pop_d0, 0);
        check("t4_rst_valid", bus.valid_out, 0);
        check("t4_rst_data", bus.data_out, 0);
        check("t4_rst_idle", bus.idle_out, 1);
        @(negedge clk);
        reset = 1'b0;
        bus.ready_in = 1'b1;
        wait_drain(30);
        check("t4_cnt_d0", bus.count_d0, 2);

        // drain_en gating
        do_reset();
        bus.drain_en = 1'b0;
        bus.ready_in = 1'b1;
        push1(6'h3A); push1(6'h3B);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("t5_no_pop", bus.pop_d1, 0);
            check("t5_not_idle", bus.idle_out, 0);
            check("t5_no_valid", bus.valid_out, 0);
        end
        @(negedge clk);
        bus.drain_en = 1'b1;
        sbq.push_back({1'b1, 6'h3A});
        #1;
        check("t5_one_pop", bus.pop_d1, 1);
        @(negedge clk);
        bus.drain_en = 1'b0;
        #1;
        check("t5_pop_off", bus.pop_d1, 0);
        repeat (4) @(negedge clk);
        #1;
        check("t5_cnt_d1", bus.count_d1, 1);
        check("t5_valid_off", bus.valid_out, 0);
        check("t5_sb_empty", sbq.size(), 0);
        @(negedge clk);
        sbq.push_back({1'b1, 6'h3B});
        bus.drain_en = 1'b1;
        wait_drain(20);
        check("t5_cnt_d1_final", bus.count_d1, 2);

        // Counter wrap: 257 D1 words
        do_reset();
        bus.drain_en = 1'b1;
        bus.ready_in = 1'b1;
        for (int i = 0; i < 257; i++) begin
            push1(6'(i));
            sbq.push_back({1'b1, 6'(i)});
        end
        wait_drain(400);
        check("t6_cnt_d1_wrap", bus.count_d1, 1);
        check("t6_cnt_d0", bus.count_d0, 0);

        check("final_sb_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
